// File: rtl/reg_file_mp.sv
// Multi-ported register file with two combinational read ports, one write port,
// optional write-to-read forwarding and a sequential clear sweep controlled by a small FSM.
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] Rd,
    input  logic [XLEN-1:0]   Write_data,
    input  logic [ADDR_W-1:0] Rs1,
    input  logic [ADDR_W-1:0] Rs2,
    output logic [XLEN-1:0]   read_data1,
    output logic [XLEN-1:0]   read_data2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic              clr_busy_r;
    logic              clr_done_r;
    logic [XLEN-1:0]   regs_r [DEPTH];

    logic              wr_en_s;
    logic [XLEN-1:0]   rd1_s;
    logic [XLEN-1:0]   rd2_s;

    // Writes are only honoured in IDLE; register 0 is never written when hardwired.
    assign wr_en_s = (state_r == IDLE) && RegWrite &&
                     !((ZERO_REG != 0) && (Rd == {ADDR_W{1'b0}}));

    // Clear FSM, sweep pointer, status flags and the storage array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            ptr_r      <= {ADDR_W{1'b0}};
            clr_busy_r <= 1'b0;
            clr_done_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            if (wr_en_s) begin
                regs_r[Rd] <= Write_data;
            end
            case (state_r)
                IDLE: begin
                    if (clr_req) begin
                        state_r    <= CLEAR;
                        ptr_r      <= {ADDR_W{1'b0}};
                        clr_busy_r <= 1'b1;
                    end
                end
                CLEAR: begin
                    regs_r[ptr_r] <= {XLEN{1'b0}};
                    // Pointer holds at the last entry rather than wrapping.
                    if (ptr_r == ADDR_W'(DEPTH - 1)) begin
                        state_r    <= DONE;
                        clr_busy_r <= 1'b0;
                        clr_done_r <= 1'b1;
                    end else begin
                        ptr_r <= ptr_r + ADDR_W'(1);
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    clr_done_r <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    ptr_r      <= {ADDR_W{1'b0}};
                    clr_busy_r <= 1'b0;
                    clr_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Read port 1: forwarding first, then hardwired zero, then array contents.
    always_comb begin
        if ((BYPASS != 0) && wr_en_s && (Rs1 == Rd)) begin
            rd1_s = Write_data;
        end else if ((ZERO_REG != 0) && (Rs1 == {ADDR_W{1'b0}})) begin
            rd1_s = {XLEN{1'b0}};
        end else begin
            rd1_s = regs_r[Rs1];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        if ((BYPASS != 0) && wr_en_s && (Rs2 == Rd)) begin
            rd2_s = Write_data;
        end else if ((ZERO_REG != 0) && (Rs2 == {ADDR_W{1'b0}})) begin
            rd2_s = {XLEN{1'b0}};
        end else begin
            rd2_s = regs_r[Rs2];
        end
    end

    assign read_data1 = rd1_s;
    assign read_data2 = rd2_s;
    assign clr_busy   = clr_busy_r;
    assign clr_done   = clr_done_r;

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, setting the data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, setting the address width; DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-004 The block SHALL have parameter BYPASS, default 1; when 1, a same-cycle write is forwarded to the read ports.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port RegWrite, input, 1 bit: write enable.
REQ-008 The block SHALL have port Rd, input, ADDR_W bits: write address.
REQ-009 The block SHALL have port Write_data, input, XLEN bits: write data.
REQ-010 The block SHALL have ports Rs1 and Rs2, inputs, ADDR_W bits each: read addresses.
REQ-011 The block SHALL have ports read_data1 and read_data2, outputs, XLEN bits each: read data.
REQ-012 The block SHALL have port clr_req, input, 1 bit: request to clear the whole file.
REQ-013 The block SHALL have port clr_busy, output, 1 bit: high while a clear sweep is in progress.
REQ-014 The block SHALL have port clr_done, output, 1 bit: single-cycle pulse when a clear sweep completes.

Function
REQ-015 Reads SHALL be combinational: read_dataN = Registers[RsN], with no clock latency.
REQ-016 Writes SHALL occur on the rising edge of clk when RegWrite=1 and the clear FSM is in IDLE.
REQ-017 With ZERO_REG=1, a read of address 0 SHALL return 0, and a write to address 0 SHALL be discarded.
REQ-018 With BYPASS=1, FSM in IDLE, RegWrite=1 and RsN==Rd (Rd!=0 when ZERO_REG=1), read_dataN SHALL equal Write_data in the same cycle.
REQ-019 With BYPASS=0, a read of the address being written SHALL return the old value until the next edge.
REQ-020 The clear FSM SHALL have exactly three states: IDLE, CLEAR and DONE.
REQ-021 IDLE: clr_req=1 at a rising edge SHALL move the FSM to CLEAR and set the pointer ptr to 0.
REQ-022 CLEAR: on each edge the FSM SHALL write 0 to Registers[ptr] and increment ptr; the edge with ptr==DEPTH-1 SHALL move the FSM to DONE.
REQ-023 DONE: the FSM SHALL stay one cycle and then return to IDLE unconditionally.
REQ-024 A clear sweep SHALL therefore take DEPTH cycles in CLEAR plus one cycle in DONE.
REQ-025 clr_busy SHALL be 1 exactly in CLEAR; clr_done SHALL be 1 exactly in DONE.
REQ-026 In CLEAR and DONE, RegWrite SHALL be ignored; the dropped write SHALL NOT be queued, and bypass SHALL be disabled.
REQ-027 In CLEAR and DONE, clr_req SHALL be ignored; a request held into IDLE SHALL start a new sweep on the next edge.
REQ-028 Reads during CLEAR SHALL return current array contents (already-cleared entries read 0).
REQ-029 ptr SHALL be ADDR_W bits wide and SHALL NOT wrap while in CLEAR.

Reset
REQ-030 reset=1 SHALL asynchronously zero all DEPTH registers, set the FSM to IDLE, set ptr to 0, and drive clr_busy=0 and clr_done=0.
REQ-031 The array SHALL have no preloaded contents; after reset, all reads SHALL return 0.
REQ-032 reset asserted mid-sweep SHALL abort the sweep; no clr_done pulse SHALL be issued.
REQ-033 The first write SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-034 Reset, then write Rd=5, data 0xDEADBEEF, then read Rs1=5 -> read_data1=0xDEADBEEF; Rs2=6 -> 0.
REQ-035 Write Rd=0, data 0x1234, with ZERO_REG=1, then read Rs1=0 -> 0 both during and after the write cycle.
REQ-036 Same cycle: RegWrite=1, Rd=7, data 0xA5, Rs2=7, with BYPASS=1 -> read_data2=0xA5 before the edge; with BYPASS=0 -> old value.
REQ-037 Fill all registers with value = index, then pulse clr_req -> clr_busy high for 32 cycles, clr_done high for 1 cycle, all reads 0; RegWrite Rd=3, data 9 during CLEAR -> Registers[3]=0 afterwards.
REQ-038 Start a sweep, assert reset at sweep cycle 10 -> clr_busy=0 immediately, all registers 0, no clr_done pulse; a new clr_req afterwards -> full 32-cycle sweep.
